// File: rtl/reg_op_pkg.sv
// rtl/reg_op_pkg.sv - shared state encoding and register-file sizes for reg_op_seq
package reg_op_pkg;
    localparam int REG_ADDR_W = 3;
    localparam int REG_DATA_W = 8;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 3'd0;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD_A = 3'd1,
        RD_B = 3'd2,
        EXEC = 3'd3,
        WB   = 3'd4
    } state_t;
endpackage

// File: rtl/reg_op_seq.sv
// rtl/reg_op_seq.sv - operand fetch, ALU handshake and writeback sequencer
// Optional: REG_OP_SEQ_ZERO_REG_EN makes register 0 read as zero and never written.
module reg_op_seq
    import reg_op_pkg::*;
#(
    parameter int ADDR_W = REG_ADDR_W,
    parameter int DATA_W = REG_DATA_W
) (
    input  logic              clk_in,
    input  logic              reset_in,
    input  logic              start_in,
    input  logic [ADDR_W-1:0] rs1_addr_in,
    input  logic [ADDR_W-1:0] rs2_addr_in,
    input  logic [ADDR_W-1:0] rd_addr_in,
    input  logic              use_rs2_in,
    input  logic              wb_en_in,
    input  logic              abort_in,
    output logic              busy_out,
    output logic              done_out,
    output logic [ADDR_W-1:0] rf_read_addr_out,
    input  logic [DATA_W-1:0] rf_read_data_in,
    output logic [ADDR_W-1:0] rf_write_addr_out,
    output logic              rf_write_en_out,
    output logic [DATA_W-1:0] rf_write_data_out,
    output logic              alu_valid_out,
    output logic [DATA_W-1:0] alu_a_out,
    output logic [DATA_W-1:0] alu_b_out,
    input  logic              alu_ack_in,
    input  logic [DATA_W-1:0] alu_result_in
);

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] rs1_q, rs2_q, rd_q;
    logic              use_rs2_q, wb_en_q;
    logic [DATA_W-1:0] op_a_q, op_b_q, result_q;
    logic [DATA_W-1:0] read_val;
    logic              wb_req;
    logic              accept;

`ifdef REG_OP_SEQ_ZERO_REG_EN
    // A write to the zero register is folded into "no writeback" at latch time.
    assign read_val = (rf_read_addr_out == ADDR_W'(ZERO_REG)) ? '0 : rf_read_data_in;
    assign wb_req   = wb_en_in && (rd_addr_in != ADDR_W'(ZERO_REG));
`else
    assign read_val = rf_read_data_in;
    assign wb_req   = wb_en_in;
`endif

    assign accept            = start_in && !abort_in;
    assign rf_write_addr_out = rd_q;
    assign rf_write_data_out = result_q;
    assign alu_a_out         = op_a_q;
    assign alu_b_out         = op_b_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) state <= IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        busy_out         = (state != IDLE);
        done_out         = 1'b0;
        rf_read_addr_out = '0;
        rf_write_en_out  = 1'b0;
        alu_valid_out    = 1'b0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = RD_A;
            end
            RD_A: begin
                rf_read_addr_out = rs1_q;
                if (abort_in)       state_nxt = IDLE;
                else if (use_rs2_q) state_nxt = RD_B;
                else                state_nxt = EXEC;
            end
            RD_B: begin
                rf_read_addr_out = rs2_q;
                state_nxt = abort_in ? IDLE : EXEC;
            end
            EXEC: begin
                alu_valid_out = 1'b1;
                if (abort_in) begin
                    state_nxt = IDLE;
                end else if (alu_ack_in) begin
                    if (wb_en_q) begin
                        state_nxt = WB;
                    end else begin
                        state_nxt = IDLE;
                        done_out  = 1'b1;
                    end
                end
            end
            WB: begin
                rf_write_en_out = 1'b1;
                done_out        = 1'b1;
                state_nxt       = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            use_rs2_q <= 1'b0;
            wb_en_q   <= 1'b0;
            op_a_q    <= '0;
            op_b_q    <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        rs1_q     <= rs1_addr_in;
                        rs2_q     <= rs2_addr_in;
                        rd_q      <= rd_addr_in;
                        use_rs2_q <= use_rs2_in;
                        wb_en_q   <= wb_req;
                    end
                end
                RD_A: begin
                    op_a_q <= read_val;
                    if (!use_rs2_q) op_b_q <= '0;
                end
                RD_B: op_b_q <= read_val;
                EXEC: begin
                    if (alu_ack_in && !abort_in) result_q <= alu_result_in;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/reg_op_seq.md
Name: reg_op_seq

Overview:
- Operand-fetch / writeback sequencer for the 8x8-bit register file, which has one combinational read port and one synchronous write port.
- Per instruction: reads up to two source registers over successive cycles through the single read port, then presents both operands to the ALU with a valid/ack handshake.
- Writes the ALU result back to the destination register and signals completion to the control unit.

Parameters:
- ADDR_W, 3, register address width (8 registers).
- DATA_W, 8, register / operand width.

Ports:
- clk_in  in  1  system clock, all state on rising edge.
- reset_in  in  1  asynchronous reset, active-low.
- start_in  in  1  request new operation; sampled only in IDLE.
- rs1_addr_in  in  ADDR_W  source A address.
- rs2_addr_in  in  ADDR_W  source B address.
- rd_addr_in  in  ADDR_W  destination address.
- use_rs2_in  in  1  1 = fetch rs2; 0 = operand B forced to 0.
- wb_en_in  in  1  1 = write result back.
- abort_in  in  1  synchronous cancel.
- busy_out  out  1  high whenever state != IDLE.
- done_out  out  1  one-cycle completion pulse.
- rf_read_addr_out  out  ADDR_W  to register file read address.
- rf_read_data_in  in  DATA_W  from register file read data.
- rf_write_addr_out  out  ADDR_W  to register file write address.
- rf_write_en_out  out  1  to register file write enable.
- rf_write_data_out  out  DATA_W  to register file write data.
- alu_valid_out  out  1  operands valid.
- alu_a_out  out  DATA_W  operand A.
- alu_b_out  out  DATA_W  operand B.
- alu_ack_in  in  1  ALU result valid this cycle.
- alu_result_in  in  DATA_W  ALU result.

Behaviour:
- Reset (reset_in=0, async): state=IDLE; latched rs1/rs2/rd/use_rs2/wb_en=0; op_a/op_b/result regs=0. All outputs 0 while in reset. A reset during WB drops rf_write_en_out immediately; no write occurs.
- IDLE:
  - rf_read_addr_out=0.
  - start_in=1 latches rs1, rs2, rd, use_rs2, wb_en, then goes to RD_A.
  - start_in outside IDLE is ignored.
- RD_A:
  - rf_read_addr_out=rs1; op_a <= rf_read_data_in at the clock edge.
  - Next state: RD_B if use_rs2=1, else EXEC with op_b <= 0.
- RD_B: rf_read_addr_out=rs2; op_b <= rf_read_data_in; next EXEC.
- EXEC:
  - alu_valid_out=1; alu_a_out/alu_b_out=op_a/op_b, held stable until ack.
  - On alu_ack_in=1: result <= alu_result_in.
    - wb_en=1: next WB.
    - wb_en=0: next IDLE with done_out=1 in this EXEC cycle.
  - alu_ack_in is ignored in all other states.
- WB:
  - rf_write_en_out=1, rf_write_addr_out=rd, rf_write_data_out=result, for exactly one cycle.
  - done_out=1 in this cycle; next IDLE.
- Outputs outside the active state: rf_write_en_out is combinational, (state==WB). rf_write_addr_out/rf_write_data_out always reflect the latched rd/result. alu_a_out/alu_b_out always reflect op_a/op_b; alu_valid_out only in EXEC.
- abort_in:
  - In RD_A, RD_B or EXEC: next state IDLE, no write, no done_out; an alu_ack_in in the same cycle is discarded.
  - In WB: ignored; the write completes.
  - In IDLE: blocks start_in that cycle.
- Latency with zero-wait ALU (ack in first EXEC cycle):
  - 2-operand op with writeback: start edge → RD_A, RD_B, EXEC, WB; done_out 4 cycles after start is sampled.
  - 1-operand op: 3 cycles.
- Back-to-back: start_in may be asserted in the first IDLE cycle after done_out. There is no IDLE-skip.
- Read-after-write: the register file updates at the WB edge, so the next operation's RD_A sees the new value.

Optional Feature:
- Macro: REG_OP_SEQ_ZERO_REG_EN.
- Defined:
  - Register 0 is hardwired zero: any operand read with address 0 loads 0 regardless of rf_read_data_in.
  - wb_en with rd=0 skips WB: done_out is asserted in EXEC as if wb_en=0, and rf_write_en_out is never asserted for address 0.
- Undefined: register 0 is an ordinary register.

Decomposition:
- Shared package reg_op_pkg:
  - state enum: IDLE, RD_A, RD_B, EXEC, WB, 3-bit encoding.
  - REG_ADDR_W=3 and REG_DATA_W=8 constants.
  - ZERO_REG=3'd0.
- Single flat module; no sub-module. The FSM and operand latches are too small to warrant a split.

Test Plan:
- Register file preloaded r1=0x12, r2=0x34. start rs1=1 rs2=2 rd=3 use_rs2=1 wb_en=1; ALU echoes a+b with immediate ack → alu_a=0x12, alu_b=0x34 in EXEC; write r3=0x46 at cycle +4; done_out one pulse; busy_out high for 4 cycles.
- use_rs2=0, rs1=1, wb_en=1 rd=4; ALU returns 0xFF after 3 wait cycles → alu_b=0x00; alu_valid held 4 cycles with stable operands; r4=0xFF; done at cycle +6.
- abort_in asserted in EXEC with alu_ack_in high → no write (r3 unchanged), no done_out; IDLE next cycle; a new start then succeeds.
- reset_in driven low mid-WB → rf_write_en_out falls asynchronously; target register unchanged; all outputs 0; state IDLE after release.
- Back-to-back: op1 writes r5=0x77, then start on the first IDLE cycle reading rs1=5 → alu_a=0x77.
- With REG_OP_SEQ_ZERO_REG_EN: r0 preloaded 0x99; read rs1=0 → alu_a=0x00; rd=0 with wb_en=1 → no write-enable pulse; done in EXEC. Without the macro: alu_a=0x99 and r0 is written.
